// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
// Shared definitions for the melody sequencer: FSM state encoding, song
// table entry layout and a helper used to build the constant song table.
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

    localparam int HP_W    = 7;              // half-period field width
    localparam int DUR_W   = 3;              // duration field width (ticks-1)
    localparam int ENTRY_W = HP_W + DUR_W;   // packed table entry width
    localparam int IDX_W   = 6;              // table index width (up to 64)

    // FSM encoding kept as plain constants for compatibility with
    // existing netlists and debug scripts.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    typedef struct packed {
        logic [HP_W-1:0]  hp;    // half-period word, 0 = rest
        logic [DUR_W-1:0] dur;   // note lasts dur+1 tempo ticks
    } song_entry_t;

    function automatic song_entry_t mk_entry(input int unsigned hp_v,
                                             input int unsigned dur_v);
        song_entry_t e;
        e.hp  = hp_v[HP_W-1:0];
        e.dur = dur_v[DUR_W-1:0];
        return e;
    endfunction

endpackage

// File: rtl/note_sequencer_rom.sv
// -----------------------------------------------------------------------------
// note_rom
// Combinational song table lookup. Entries at or beyond SONG_LEN read as 0.
//
// Ports:
//   addr   in  6   table index
//   entry  out 10  {hp[6:0], dur[2:0]} of the addressed entry
// -----------------------------------------------------------------------------
module note_rom
    import note_sequencer_pkg::*;
#(
    parameter int SONG_LEN = 16
) (
    input  logic [IDX_W-1:0] addr,
    output song_entry_t      entry
);

    localparam logic [IDX_W:0] LEN_W = (IDX_W + 1)'(SONG_LEN);

    always_comb begin
        entry = '0;
        if ({1'b0, addr} < LEN_W) begin
            case (addr)
                6'd0:    entry = mk_entry(20, 1);
                6'd1:    entry = mk_entry(0,  0);
                6'd2:    entry = mk_entry(45, 2);
                6'd3:    entry = mk_entry(38, 1);
                6'd4:    entry = mk_entry(34, 1);
                6'd5:    entry = mk_entry(30, 3);
                6'd6:    entry = mk_entry(0,  0);
                6'd7:    entry = mk_entry(30, 1);
                6'd8:    entry = mk_entry(34, 1);
                6'd9:    entry = mk_entry(38, 3);
                6'd10:   entry = mk_entry(0,  0);
                6'd11:   entry = mk_entry(25, 1);
                6'd12:   entry = mk_entry(28, 1);
                6'd13:   entry = mk_entry(30, 1);
                6'd14:   entry = mk_entry(38, 1);
                6'd15:   entry = mk_entry(20, 7);
                default: entry = '0;
            endcase
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Steps through the constant song table and drives the square-wave
// synthesiser's half-period word and enable. One-shot or looped playback,
// abort, and a one-cycle end-of-song pulse.
//
// Optional feature: define NOTE_SEQ_GAP_EN to insert GAP_TICKS silent ticks
// after every note (articulation). Without it notes play back-to-back.
//
// Ports:
//   clk       in   1  clock
//   rst       in   1  synchronous reset, active-high
//   start     in   1  begin playback from entry 0 (IDLE only)
//   stop      in   1  abort playback, any state
//   loop_en   in   1  wrap to entry 0 after the last entry
//   hp        out  7  half-period word (0 when idle)
//   active    out  1  synthesiser enable
//   note_idx  out  6  current table entry
//   busy      out  1  playback in progress
//   done      out  1  one-cycle pulse at end of a non-looped song
// -----------------------------------------------------------------------------
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int TICK_DIV  = 250000,
    parameter int SONG_LEN  = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [HP_W-1:0]  hp,
    output logic             active,
    output logic [IDX_W-1:0] note_idx,
    output logic             busy,
    output logic             done
);

    if (TICK_DIV < 2 || SONG_LEN < 1 || SONG_LEN > 64 || GAP_TICKS < 1) begin : g_bad_param
        $error("note_sequencer: parameter out of range");
    end

    localparam int               PW       = $clog2(TICK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    logic [1:0]       state;
    logic             start_pend;   // start accepted, entry 0 loads next edge
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] tcnt;
    logic [DUR_W-1:0] cur_dur;
    logic             tick;
    logic             note_end;
    logic             advance;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] rom_addr;
    song_entry_t      rom_q;

`ifdef NOTE_SEQ_GAP_EN
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    logic [GW-1:0] gap_cnt;
`endif

    note_rom #(
        .SONG_LEN (SONG_LEN)
    ) u_rom (
        .addr  (rom_addr),
        .entry (rom_q)
    );

    always_comb begin
        tick     = (presc == PW'(TICK_DIV - 1));
        next_idx = (note_idx == LAST_IDX) ? '0 : note_idx + 6'd1;
        // In IDLE the only entry ever loaded is entry 0; otherwise the ROM
        // is pre-addressed with the entry that follows the current one.
        rom_addr = (state == IDLE) ? '0 : next_idx;
        note_end = (state == PLAY) && tick && (tcnt == cur_dur);
`ifdef NOTE_SEQ_GAP_EN
        advance  = (state == GAP) && tick && (gap_cnt == GW'(GAP_TICKS - 1));
`else
        advance  = note_end;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start_pend <= 1'b0;
            presc      <= '0;
            tcnt       <= '0;
            cur_dur    <= '0;
            hp         <= '0;
            active     <= 1'b0;
            note_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef NOTE_SEQ_GAP_EN
            gap_cnt    <= '0;
`endif
        end else if (stop) begin
            state      <= IDLE;
            start_pend <= 1'b0;
            presc      <= '0;
            tcnt       <= '0;
            hp         <= '0;
            active     <= 1'b0;
            note_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == IDLE || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (advance) begin
                if (note_idx != LAST_IDX || loop_en) begin
                    state    <= PLAY;
                    note_idx <= next_idx;
                    hp       <= rom_q.hp;
                    active   <= (rom_q.hp != '0);
                    cur_dur  <= rom_q.dur;
                    tcnt     <= '0;
                end else begin
                    state    <= IDLE;
                    note_idx <= '0;
                    hp       <= '0;
                    active   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    tcnt     <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start_pend) begin
                            start_pend <= 1'b0;
                            state      <= PLAY;
                            note_idx   <= '0;
                            hp         <= rom_q.hp;
                            active     <= (rom_q.hp != '0);
                            cur_dur    <= rom_q.dur;
                            busy       <= 1'b1;
                            tcnt       <= '0;
                        end else if (start) begin
                            start_pend <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
`ifdef NOTE_SEQ_GAP_EN
                            if (note_end) begin
                                // hp is held so the synthesiser word stays stable
                                state   <= GAP;
                                active  <= 1'b0;
                                gap_cnt <= '0;
                                tcnt    <= '0;
                            end else begin
                                tcnt <= tcnt + 3'd1;
                            end
`else
                            tcnt <= tcnt + 3'd1;
`endif
                        end
                    end
`ifdef NOTE_SEQ_GAP_EN
                    GAP: begin
                        if (tick) begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer with TICK_DIV=4 and the three-entry test song
// {20,1}, {0,0}, {45,2}. Expectations follow the build's NOTE_SEQ_GAP_EN setting.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [6:0] hp;
    logic       active;
    logic [5:0] note_idx;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    note_sequencer #(
        .TICK_DIV  (4),
        .SONG_LEN  (3),
        .GAP_TICKS (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .hp       (hp),
        .active   (active),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One record per output segment: expected outputs held for n cycles.
    typedef struct {
        logic [6:0]  hp;
        logic        act;
        logic [5:0]  idx;
        logic        busy;
        logic        done;
        int unsigned n;
    } row_t;

    row_t rows[8];
    int   song_rows;
    int   e2_row;
    int   poke_e1;

    task automatic chk(input string name, input logic [6:0] ehp, input logic ea,
                       input logic [5:0] ei, input logic eb, input logic ed);
        n_cmp++;
        if ({hp, active, note_idx, busy, done} !== {ehp, ea, ei, eb, ed}) begin
            n_bad++;
            $display("FAIL %s t=%0t: got hp=%0d active=%b idx=%0d busy=%b done=%b, want hp=%0d active=%b idx=%0d busy=%b done=%b",
                     name, $time, hp, active, note_idx, busy, done, ehp, ea, ei, eb, ed);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, 7'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_row(input string name, input int r);
        chk(name, rows[r].hp, rows[r].act, rows[r].idx, rows[r].busy, rows[r].done);
    endtask

    // Walk rows lo..hi, one check per cycle at the falling edge. If poke >= 0,
    // start is pulsed for one cycle after that many checks.
    task automatic run_rows(input string name, input int lo, input int hi, input int poke);
        int cyc = 0;
        for (int r = lo; r <= hi; r++) begin
            for (int unsigned k = 0; k < rows[r].n; k++) begin
                @(negedge clk);
                chk_row(name, r);
                cyc++;
                start = (cyc == poke);
            end
        end
        start = 1'b0;
    endtask

    // Pulse start for one cycle and check that nothing is visible yet.
    task automatic kick(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_idle(name);
    endtask

    initial begin
`ifdef NOTE_SEQ_GAP_EN
        rows[0] = '{7'd20, 1'b1, 6'd0, 1'b1, 1'b0, 8};
        rows[1] = '{7'd20, 1'b0, 6'd0, 1'b1, 1'b0, 4};
        rows[2] = '{7'd0,  1'b0, 6'd1, 1'b1, 1'b0, 4};
        rows[3] = '{7'd0,  1'b0, 6'd1, 1'b1, 1'b0, 4};
        rows[4] = '{7'd45, 1'b1, 6'd2, 1'b1, 1'b0, 12};
        rows[5] = '{7'd45, 1'b0, 6'd2, 1'b1, 1'b0, 4};
        song_rows = 6;
        e2_row    = 4;
        poke_e1   = 14;
`else
        rows[0] = '{7'd20, 1'b1, 6'd0, 1'b1, 1'b0, 8};
        rows[1] = '{7'd0,  1'b0, 6'd1, 1'b1, 1'b0, 4};
        rows[2] = '{7'd45, 1'b1, 6'd2, 1'b1, 1'b0, 12};
        rows[3] = '{7'd0,  1'b0, 6'd0, 1'b0, 1'b1, 1};
        rows[4] = '{7'd0,  1'b0, 6'd0, 1'b0, 1'b0, 3};
        song_rows = 3;
        e2_row    = 2;
        poke_e1   = 9;
`endif
        // Trailing rows: done pulse, then idle with no restart.
        rows[song_rows]     = '{7'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1};
        rows[song_rows + 1] = '{7'd0, 1'b0, 6'd0, 1'b0, 1'b0, 3};

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle_after_reset");

        // Basic one-shot playback.
        kick("basic_latency");
        run_rows("basic", 0, song_rows + 1, -1);

        // Looped playback: first pass wraps to entry 0 without done, then
        // loop_en is dropped and the second pass ends with done.
        loop_en = 1'b1;
        kick("loop_latency");
        run_rows("loop_pass1", 0, song_rows - 1, -1);
        run_rows("loop_wrap", 0, 0, -1);
        loop_en = 1'b0;
        run_rows("loop_pass2", 1, song_rows + 1, -1);

        // Abort 5 cycles into entry 2.
        kick("abort_latency");
        run_rows("abort_pre", 0, e2_row - 1, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_row("abort_e2", e2_row);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_idle("abort_idle");
        @(negedge clk);
        chk_idle("abort_no_done");

        // start together with stop in IDLE: stays idle.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_idle("start_stop_1");
        @(negedge clk);
        chk_idle("start_stop_2");
        @(negedge clk);
        chk_idle("start_stop_3");

        // Reset mid-note, then full replay from entry 0.
        kick("rst_latency");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_row("rst_pre", 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_mid_note");
        kick("replay_latency");
        run_rows("replay", 0, song_rows + 1, -1);

        // start pulsed during entry 1 has no effect on the timing.
        kick("busy_latency");
        run_rows("busy_start", 0, song_rows + 1, poke_e1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want end before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
